// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard interface: operand/destination info in, stall and bypass selects out.
// Latency: none of its own; it only carries signals.
// Backpressure: dhs=0 from the scoreboard holds decode/fetch and inserts a bubble.
interface hazard_scoreboard_if #(
  parameter int REG_AW = 3,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 8
);
  logic [REG_AW-1:0] aa;
  logic [REG_AW-1:0] ba;
  logic [REG_AW-1:0] da;
  logic              rw;
  logic              ma;
  logic              mb;
  logic              md;
  logic              id_valid;
  logic              flush;
  logic              dhs;
  logic [SEL_W-1:0]  fwd_a_sel;
  logic [SEL_W-1:0]  fwd_b_sel;
  logic [CNT_W-1:0]  stall_cnt;

  // Decode stage drives instruction info and consumes stall/bypass.
  modport master (
    output aa, ba, da, rw, ma, mb, md, id_valid, flush,
    input  dhs, fwd_a_sel, fwd_b_sel, stall_cnt
  );

  // Scoreboard consumes instruction info and produces stall/bypass.
  modport slave (
    input  aa, ba, da, rw, ma, mb, md, id_valid, flush,
    output dhs, fwd_a_sel, fwd_b_sel, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: tracks DEPTH in-flight destinations, yields bypass selects or a stall.
// Latency: dhs and fwd selects are combinational from decode inputs; entries update each edge.
// Backpressure: dhs=0 stalls decode/fetch; the stalled slot enters the pipe as a bubble.
module hazard_scoreboard #(
  parameter int REG_AW = 3,
  parameter int DEPTH  = 2,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 8,
  parameter int SEL_W  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_scoreboard_if.slave   hs
);

  // Entry k: valid, destination register, load flag. Entry 0 is EX.
  logic [DEPTH-1:0]  v;
  logic [DEPTH-1:0]  ld;
  logic [REG_AW-1:0] dst [DEPTH];

  logic              haz_a;
  logic              haz_b;
  logic [SEL_W-1:0]  sel_a;
  logic [SEL_W-1:0]  sel_b;
  logic              dhs_int;
  logic [CNT_W-1:0]  cnt;

  // Operand match search; scanning oldest to youngest lets the youngest match win.
  always_comb begin
    haz_a = 1'b0;
    haz_b = 1'b0;
    sel_a = '0;
    sel_b = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (v[k] && dst[k] == hs.aa && hs.aa != '0 && !hs.ma && hs.id_valid) begin
        if (FWD_EN == 0 || (ld[k] && k == 0)) begin
          haz_a = 1'b1;
          sel_a = '0;
        end else begin
          haz_a = 1'b0;
          sel_a = SEL_W'(k + 1);
        end
      end
      if (v[k] && dst[k] == hs.ba && hs.ba != '0 && !hs.mb && hs.id_valid) begin
        if (FWD_EN == 0 || (ld[k] && k == 0)) begin
          haz_b = 1'b1;
          sel_b = '0;
        end else begin
          haz_b = 1'b0;
          sel_b = SEL_W'(k + 1);
        end
      end
    end
  end

  // A taken branch kills the decode instruction, so it never stalls.
  assign dhs_int      = hs.flush | ~(haz_a | haz_b);
  assign hs.dhs       = dhs_int;
  assign hs.fwd_a_sel = dhs_int ? sel_a : '0;
  assign hs.fwd_b_sel = dhs_int ? sel_b : '0;
  assign hs.stall_cnt = cnt;

  // Shift the scoreboard; load entry 0 with the issuing instruction or a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v  <= '0;
      ld <= '0;
      for (int k = 0; k < DEPTH; k++) dst[k] <= '0;
    end else begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        v[k]   <= v[k-1] & ~hs.flush;
        ld[k]  <= ld[k-1];
        dst[k] <= dst[k-1];
      end
      v[0]   <= hs.id_valid & dhs_int & hs.rw & (hs.da != '0) & ~hs.flush;
      ld[0]  <= hs.md;
      dst[0] <= hs.da;
    end
  end

  // Saturating count of stalled cycles; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!dhs_int && cnt != {CNT_W{1'b1}}) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised RAW hazard unit for the pipelined RISC core. It tracks in-flight destination registers across DEPTH post-decode stages in a shift-register scoreboard. For each decode-stage operand it either generates a forwarding select or asserts an active-low stall (dhs). Sits beside the decode stage, driving the PC/IR hold, bubble insertion and operand bypass muxes.

Parameters:
REG_AW, 3, register address width (register 0 hardwired zero, never a hazard source)
DEPTH, 2, number of tracked in-flight stages after decode (entry 0 = EX, entry DEPTH-1 = last before writeback); range 1..7
FWD_EN, 1, 1 = forward where possible, stall only on load-use; 0 = stall on any match
CNT_W, 8, width of saturating stall counter
SEL_W, 3, width of forward selects; must satisfy 2^SEL_W > DEPTH

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
aa  input  REG_AW  decode operand A address
ba  input  REG_AW  decode operand B address
da  input  REG_AW  decode destination address
rw  input  1  decode instruction writes register file
ma  input  1  1 = operand A from constant/PC, not register (no hazard on A)
mb  input  1  1 = operand B from constant, not register (no hazard on B)
md  input  1  decode instruction is a load (result available one stage late)
id_valid  input  1  decode stage holds a real instruction
flush  input  1  branch taken: kill all tracked entries and the decode instruction
dhs  output  1  0 = stall decode/fetch and insert bubble; 1 = proceed
fwd_a_sel  output  SEL_W  operand A bypass: 0 = register file, k = result of entry k-1
fwd_b_sel  output  SEL_W  operand B bypass, same encoding
stall_cnt  output  CNT_W  cycles with dhs=0, saturating

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Scoreboard entry = {v, dst[REG_AW], ld}. Reset: all v=0, stall_cnt=0. Hence dhs=1, fwd selects=0 during and after reset.
- Every rising edge: entries shift k -> k+1; entry DEPTH-1 retires. Writeback is write-through, so there is no hazard after retirement.
- Entry 0 load, normally: v = id_valid & dhs & rw & (da != 0); dst = da; ld = md.
- Entry 0 load, bubble: v=0 when id_valid=0 or dhs=0.
- flush=1: all entries get v=0 on the next edge (including the new entry 0); flush dominates issue and stall.
- Match A on entry k: v[k] & dst[k]==aa & aa!=0 & ~ma & id_valid. Match B is the same with ba/mb.
- Combinational outputs (same cycle as inputs). The youngest match wins (lowest k).
- FWD_EN=1: youngest match non-load, or load with k>=1 -> fwd_sel = k+1. Youngest match is a load at k=0 -> hazard.
- FWD_EN=0: any match -> hazard; fwd selects held 0.
- dhs = ~(hazard_A | hazard_B). While dhs=0, fwd selects are don't-care; drive 0.
- flush=1 forces dhs=1 in that cycle.
- stall_cnt increments on each edge where dhs=0, saturates at 2^CNT_W-1, and is cleared only by rst_n.
- Stall resolves without external action: bubbles propagate until the producer moves past the stalling position.
- Stall lengths: FWD_EN=0 -> up to DEPTH cycles; FWD_EN=1 -> exactly 1 cycle for load-use.
- Reset asserted mid-stall: entries clear immediately (async), dhs=1 immediately.

Test Plan:
- Reset, FWD_EN=0, DEPTH=2: issue da=3,rw=1; next cycle aa=3,ma=0 -> dhs=0 for 2 cycles, then 1; stall_cnt=2.
- FWD_EN=1: ALU op da=5; next cycle ba=5,mb=0 -> dhs=1, fwd_b_sel=1. One instruction later (independent in between) -> fwd_b_sel=2.
- FWD_EN=1 load-use: md=1,da=2; next aa=2 -> dhs=0 for exactly 1 cycle, then fwd_a_sel=2, stall_cnt +1.
- Register 0 / mux bypass: producer da=0 rw=1, consumer aa=0 -> dhs=1, sel=0. Producer da=4, consumer aa=4 with ma=1 -> dhs=1, sel=0.
- Youngest-wins: entries k=0 and k=1 both dst=6 (ALU); aa=6 -> fwd_a_sel=1. flush=1 during pending load-use stall -> dhs=1 same cycle, all entries invalid next cycle.
- Saturation/reset: CNT_W=2, force 5 stall cycles -> stall_cnt=3. Pulse rst_n=0 mid-stall -> dhs=1 and stall_cnt=0 asynchronously.
